// File: rtl/risc_data_mem_param_if.sv
// Request/response bundle between a load/store unit and risc_data_mem_param.
// The master drives the access; the slave returns ready, load data and error pulses.
interface risc_data_mem_param_if #(
  parameter int ADDR_W = 6
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;
  logic              init_busy;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  ready, rvalid, rdata, err, init_busy
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output ready, rvalid, rdata, err, init_busy
  );
endinterface

// File: rtl/risc_data_mem_param.sv
// Byte-addressable 32-bit data memory with a post-reset initialisation sweep,
// lane-masked stores, extended loads and a one-cycle error pulse for illegal accesses.
module risc_data_mem_param #(
  parameter int ADDR_W    = 6,
  parameter int INIT_MODE = 1
) (
  input logic                   CLK,
  input logic                   reset,
  risc_data_mem_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;
  logic              r_busy;
  logic              r_rvalid;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_acc;
  logic              w_bad;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_widx;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;

  function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   is_bad = 1'b0;
      2'b01:   is_bad = off[0];
      2'b10:   is_bad = (off != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] off, input logic u);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      2'b00:   load_ext = u ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_ext = u ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  // Write port: sweep writes win during INIT, accepted legal stores in RUN.
  always_comb begin
    w_acc   = bus.req & r_ready;
    w_bad   = is_bad(bus.size, bus.addr[1:0]);
    w_idx   = bus.addr[ADDR_W+1:2];
    w_widx  = w_idx;
    w_wdata = store_data(bus.size, bus.wdata);
    w_be    = 4'b0000;
    if (reset) begin
      w_be = 4'b0000;
    end else if (r_state == ST_INIT) begin
      w_be    = 4'b1111;
      w_widx  = r_cnt;
      w_wdata = (INIT_MODE == 32'sd1) ? {{(32-ADDR_W){1'b0}}, r_cnt} : 32'h0000_0000;
    end else if (w_acc && bus.we && !w_bad) begin
      w_be = store_be(bus.size, bus.addr[1:0]);
    end else begin
      w_be = 4'b0000;
    end
  end

  // Memory array with per-byte write enables.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) begin
        r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Sweep/run FSM with registered handshake and response outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_rvalid <= 1'b0;
          r_err    <= 1'b0;
          if (r_cnt == {ADDR_W{1'b1}}) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          r_rvalid <= w_acc & ~bus.we & ~w_bad;
          r_err    <= w_acc & w_bad;
          // Read sees the array before this edge, so a store one cycle earlier is visible.
          if (w_acc && !bus.we && !w_bad) begin
            r_rdata <= load_ext(r_mem[w_idx], bus.size, bus.addr[1:0], bus.uns);
          end
        end
        default: begin
          r_state  <= ST_INIT;
          r_cnt    <= '0;
          r_ready  <= 1'b0;
          r_busy   <= 1'b1;
          r_rvalid <= 1'b0;
          r_err    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.init_busy = r_busy;
  assign bus.rvalid    = r_rvalid;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
endmodule

// File: tb/tb_risc_data_mem_param.sv
// Directed bench for risc_data_mem_param (ADDR_W=6, INIT_MODE=1) with hand-computed expectations.
module tb_risc_data_mem_param;
  logic CLK;
  logic reset;
  int   errors;
  int   checks;
  int   n;
  int   resp;
  logic [31:0] held;

  risc_data_mem_param_if #(.ADDR_W(6)) bus ();

  risc_data_mem_param #(.ADDR_W(6), .INIT_MODE(1)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_acc(input logic w, input logic [1:0] sz, input logic u,
                         input logic [7:0] a, input logic [31:0] d);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.size  = sz;
    bus.uns   = u;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  // One accepted access; outputs are observed just after the accepting edge.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [7:0] a, input logic [31:0] d);
    set_acc(w, sz, u, a, d);
    step();
    bus.req = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    set_acc(1'b0, 2'b10, 1'b0, 8'h00, 32'h0);
    bus.req = 1'b0;

    step();
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.init_busy}, 32'd1);
    chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);

    reset = 1'b0;
    n = 1;
    while (bus.init_busy && n < 200) begin
      chk("sweep_ready_low", {31'd0, bus.ready}, 32'd0);
      step();
      if (bus.init_busy) n++;
    end
    chk("sweep_len", n, 32'd64);
    chk("run_ready", {31'd0, bus.ready}, 32'd1);

    access(1'b0, 2'b10, 1'b0, 8'h14, 32'h0);
    chk("ld14_rvalid", {31'd0, bus.rvalid}, 32'd1);
    chk("ld14_rdata", bus.rdata, 32'd5);
    chk("ld14_err", {31'd0, bus.err}, 32'd0);

    access(1'b1, 2'b00, 1'b0, 8'h21, 32'h0000_005A);
    chk("stb_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("stb_err", {31'd0, bus.err}, 32'd0);
    access(1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
    chk("byte_merge", bus.rdata, 32'h0000_5A08);

    access(1'b1, 2'b01, 1'b0, 8'h2A, 32'h1234_BEEF);
    access(1'b0, 2'b10, 1'b0, 8'h28, 32'h0);
    chk("half_merge", bus.rdata, 32'hBEEF_000A);

    access(1'b1, 2'b10, 1'b0, 8'h20, 32'hDEAD_BEEF);
    chk("stw_err", {31'd0, bus.err}, 32'd0);
    access(1'b0, 2'b00, 1'b0, 8'h23, 32'h0);
    chk("lb_s_23", bus.rdata, 32'hFFFF_FFDE);
    access(1'b0, 2'b00, 1'b1, 8'h23, 32'h0);
    chk("lb_u_23", bus.rdata, 32'h0000_00DE);
    access(1'b0, 2'b01, 1'b0, 8'h22, 32'h0);
    chk("lh_s_22", bus.rdata, 32'hFFFF_DEAD);
    access(1'b0, 2'b01, 1'b1, 8'h20, 32'h0);
    chk("lh_u_20", bus.rdata, 32'h0000_BEEF);
    access(1'b0, 2'b00, 1'b0, 8'h21, 32'h0);
    chk("lb_s_21", bus.rdata, 32'hFFFF_FFBE);
    held = bus.rdata;
    step();
    step();
    chk("hold_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("hold_rdata", bus.rdata, 32'hFFFF_FFBE);

    access(1'b0, 2'b10, 1'b0, 8'h06, 32'h0);
    chk("mis_w_err", {31'd0, bus.err}, 32'd1);
    chk("mis_w_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("mis_w_rdata", bus.rdata, held);
    step();
    chk("err_pulse_end", {31'd0, bus.err}, 32'd0);
    access(1'b1, 2'b01, 1'b0, 8'h01, 32'h0000_FFFF);
    chk("mis_h_err", {31'd0, bus.err}, 32'd1);
    access(1'b1, 2'b11, 1'b0, 8'h0C, 32'h1234_5678);
    chk("sz11_st_err", {31'd0, bus.err}, 32'd1);
    access(1'b0, 2'b11, 1'b0, 8'h08, 32'h0);
    chk("sz11_ld_err", {31'd0, bus.err}, 32'd1);
    chk("sz11_ld_rvalid", {31'd0, bus.rvalid}, 32'd0);
    access(1'b0, 2'b10, 1'b0, 8'h00, 32'h0);
    chk("mem0_unchanged", bus.rdata, 32'd0);
    access(1'b0, 2'b10, 1'b0, 8'h0C, 32'h0);
    chk("mem3_unchanged", bus.rdata, 32'd3);

    for (int k = 0; k < 4; k++) begin
      set_acc(1'b1, 2'b10, 1'b0, 8'h3C, 32'hA500_0000 + k);
      step();
      chk("alt_st_rvalid", {31'd0, bus.rvalid}, 32'd0);
      set_acc(1'b0, 2'b10, 1'b0, 8'h3C, 32'h0);
      step();
      chk("alt_ld_rvalid", {31'd0, bus.rvalid}, 32'd1);
      chk("alt_ld_rdata", bus.rdata, 32'hA500_0000 + k);
    end

    // Reset with a load pending and a request held: priority and discard.
    set_acc(1'b0, 2'b10, 1'b0, 8'h14, 32'h0);
    reset = 1'b1;
    step();
    chk("rst_run_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_run_rdata", bus.rdata, 32'd0);
    chk("rst_run_busy", {31'd0, bus.init_busy}, 32'd1);
    reset = 1'b0;
    resp = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.rvalid || bus.err || bus.ready) resp++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 1;
    while (bus.init_busy && n < 200) begin
      step();
      if (bus.rvalid || bus.err) resp++;
      if (bus.init_busy) n++;
    end
    chk("resweep_len", n, 32'd64);
    chk("resweep_no_resp", resp, 32'd0);
    chk("resweep_ready", {31'd0, bus.ready}, 32'd1);
    step();
    chk("held_req_rvalid", {31'd0, bus.rvalid}, 32'd1);
    chk("held_req_rdata", bus.rdata, 32'd5);
    bus.req = 1'b0;
    access(1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
    chk("reinit_word8", bus.rdata, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/risc_data_mem_param.md
RISC_DATA_MEM_PARAM -- requirements
Module: risc_data_mem_param

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6: word-address bits; DEPTH = 2**ADDR_W words of 32 bits.
REQ-002 The block SHALL have parameter INIT_MODE, default 1: 0 = zero fill, 1 = word i holds value i (zero-extended).
REQ-003 The block SHALL have port CLK, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1 bit: access request.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 The block SHALL have port uns, input, 1 bit: load zero-extends when 1 and sign-extends when 0.
REQ-009 The block SHALL have port addr, input, ADDR_W+2 bits: byte address; word index = addr[ADDR_W+1:2].
REQ-010 The block SHALL have port wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 The block SHALL have port ready, output, 1 bit: block accepts req this cycle.
REQ-012 The block SHALL have port rvalid, output, 1 bit: one-cycle pulse marking valid rdata.
REQ-013 The block SHALL have port rdata, output, 32 bits: extended load result.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected access.
REQ-015 The block SHALL have port init_busy, output, 1 bit: initialisation sweep in progress.

Function
REQ-016 The block SHALL implement a two-state FSM: INIT (sweep) and RUN; ready = 1 only in RUN.
REQ-017 In INIT, the block SHALL write one word per cycle from counter 0 up to DEPTH-1 with the INIT_MODE value, then enter RUN; the sweep lasts DEPTH cycles after reset deasserts.
REQ-018 The block SHALL accept an access only when req and ready are both 1; req during INIT SHALL be ignored, with no response.
REQ-019 For an accepted store, the block SHALL write only the addressed lanes: byte lane addr[1:0]; half lanes {addr[1],0} and {addr[1],1}; word all 4; the other lanes are unchanged.
REQ-020 For an accepted load, the block SHALL pulse rvalid exactly 1 cycle later, with rdata = the selected byte or half shifted to bit 0 and extended per uns; a word load returns the raw word.
REQ-021 rdata SHALL hold its value until the next rvalid pulse.
REQ-022 A store followed in the next cycle by a load of the same word SHALL return the new data.
REQ-023 Misalignment is a half with addr[0] = 1 or a word with addr[1:0] != 0; for a misaligned or size = 11 access, the block SHALL leave memory unchanged, pulse err 1 cycle later, and SHALL NOT pulse rvalid.
REQ-024 A store SHALL never assert rvalid; a legal store SHALL never assert err.
REQ-025 The block SHALL accept back-to-back accesses, one per cycle, in RUN.
REQ-026 Memory contents and outputs are undefined until the first reset.

Reset
REQ-027 While reset = 1, the block SHALL set state = INIT, counter = 0, ready = 0, rvalid = 0, err = 0, rdata = 0, and init_busy = 1.
REQ-028 A reset asserted mid-sweep or mid-RUN SHALL restart the sweep at word 0 and discard any pending rvalid or err.
REQ-029 reset SHALL take priority over any access presented in the same cycle.
REQ-030 init_busy SHALL fall and ready SHALL rise in the same cycle that the FSM enters RUN.

Verification
REQ-031 Reset 1 cycle, then release: init_busy = 1 for 64 cycles, then ready = 1; a word load of addr 0x14 returns 5 (INIT_MODE = 1).
REQ-032 Store word 0xDEADBEEF at 0x20, then load byte at 0x23 with uns = 0 -> 0xFFFFFFDE; load byte with uns = 1 -> 0x000000DE; load half at 0x22 with uns = 0 -> 0xFFFFDEAD.
REQ-033 Store byte 0x5A at 0x21 over word 8 -> word load of 0x20 returns 0x00005A08.
REQ-034 Word load at 0x06, half store at 0x01, and size = 11 each -> err pulses 1 cycle later, no rvalid, memory unchanged.
REQ-035 Reset asserted at sweep cycle 30 -> sweep restarts and ready rises 64 cycles after release; a req held throughout gets no response until ready = 1.
REQ-036 Alternating store/load every cycle to the same word at 0x3C -> each rvalid returns the just-written value.
